reg_writeback: RTL and testbench
================================

REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, depth of the MDU result buffer (power of two, >=2).
REQ-002 clk  in  1  single clock, all state rising-edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state.
REQ-004 issue_en  in  1  decode issues an instruction that writes issue_rd.
REQ-005 issue_rd  in  5  destination of issuing instruction.
REQ-006 issue_rs1_en / issue_rs1  in  1/5  source 1 read request and address.
REQ-007 issue_rs2_en / issue_rs2  in  1/5  source 2 read request and address.
REQ-008 alu_valid / alu_rd / alu_data  in  1/5/32  single-cycle ALU result; no backpressure, always accepted.
REQ-009 mdu_valid / mdu_rd / mdu_data  in  1/5/32  multiply/divide result offer.
REQ-010 mdu_ready  out  1  MDU result accepted on edge where mdu_valid && mdu_ready.
REQ-011 wr_rd_en / rd_address / rd_data  out  1/5/32  register-file write port, registered.
REQ-012 reg_rd_stall  out  1  combinational hazard stall to decode and register file.
REQ-013 busy  out  1  any pending destination or buffered MDU result.

Function
REQ-014 Write port SHALL be registered: a result accepted at edge N appears on wr_rd_en/rd_address/rd_data for cycle N+1 only.
REQ-015 Priority per cycle: ALU result > oldest FIFO entry; MDU results always pass through the FIFO (no bypass).
REQ-016 FIFO pops only in cycles with alu_valid low; pop and push in the same cycle SHALL be allowed when not full.
REQ-017 mdu_ready SHALL equal (FIFO count < FIFO_DEPTH), derived from registered count only; no push when full even if popping.
REQ-018 Results with rd == 0 SHALL be consumed (FIFO popped / ALU accepted) but SHALL NOT assert wr_rd_en.
REQ-019 Cycles with no write selected: wr_rd_en = 0, rd_address and rd_data hold previous values.
REQ-020 Scoreboard: 32-bit pending vector; bit r set at edge where issue_en && !reg_rd_stall && issue_rd == r && r != 0.
REQ-021 Bit r cleared at the same edge the write port loads a write with rd_address == r; bit 0 never set.
REQ-022 reg_rd_stall = (issue_rs1_en && pending[issue_rs1]) || (issue_rs2_en && pending[issue_rs2]) || (issue_en && pending[issue_rd]) (RAW and WAW).
REQ-023 Stall SHALL use current pending only; a clear on the coming edge does not drop stall this cycle (register-file write forwarding covers the following cycle).
REQ-024 issue_en while reg_rd_stall is high SHALL be ignored (no scoreboard set).
REQ-025 A result arriving for a destination whose pending bit is clear SHALL still be written (no error, no bit change).
REQ-026 busy = (|pending) || (FIFO count != 0) || wr_rd_en.
REQ-027 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.

Reset
REQ-028 On reset assertion, immediately: pending = 0, FIFO count/pointers = 0, wr_rd_en = 0, rd_address = 0, rd_data = 0.
REQ-029 During reset: mdu_ready = 1, reg_rd_stall = 0, busy = 0; inputs ignored; results in flight are discarded.
REQ-030 First acceptance on the first rising edge after reset deasserts.

Structure
REQ-031 Shared package rv_pkg SHALL hold XLEN = 32, REG_ADDR_W = 5, and typedef wb_result_t {rd, data}.
REQ-032 FIFO SHALL be a sub-module wb_fifo (parameterised depth, wb_result_t payload, push/pop/full/empty/count).
REQ-033 Scoreboard, arbitration and output register stay in reg_writeback.

Verification
REQ-034 issue_en rd=5; next cycle alu_valid rd=5 data=0x1234_5678 -> cycle after: wr_rd_en=1, rd_address=5, rd_data=0x12345678; pending[5] clears at that edge.
REQ-035 pending[7] set; issue rs1=7 -> reg_rd_stall=1 until the cycle wr_rd_en writes rd 7, then 0 next cycle.
REQ-036 alu_valid rd=3 and mdu_valid rd=4 same cycle -> rd 3 written at N+1, rd 4 at N+2.
REQ-037 alu_valid held high 4 cycles, mdu_valid high 3 cycles (rd 8,9,10) -> mdu_ready drops after 2 accepts; MDU writes 8,9,10 follow ALU writes in order.
REQ-038 alu_valid rd=0 data=0xFFFF_FFFF -> wr_rd_en stays 0; issue_en rd=0 -> no stall ever.
REQ-039 Reset asserted mid-run with FIFO holding 2 entries and pending[12] set -> outputs per REQ-028/029 asynchronously; no write after release.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared register-writeback definitions: datapath widths and the result payload
// carried from the execution units to the register-file write port.
package rv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  // One result headed for the register file.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_result_t;

endpackage : rv_pkg

// File: rtl/wb_fifo.sv
// Small circular buffer holding MDU results until the write port is free.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push, push_data     enqueue one result (ignored when full)
//   pop, pop_data       dequeue the head (ignored when empty); pop_data = head
//   full, empty, count  occupancy, count derived from registered state only
module wb_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  wb_result_t                 push_data,
  input  logic                       pop,
  output wb_result_t                 pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_result_t             mem_q [DEPTH];
  logic [PTR_W-1:0]       wptr_q, wptr_d;
  logic [PTR_W-1:0]       rptr_q, rptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   do_push;
  logic                   do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PTR_W'(1);
    if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

endmodule : wb_fifo

// File: rtl/reg_writeback.sv
// Register writeback stage: arbitrates ALU and buffered MDU results onto a
// registered register-file write port and tracks pending destinations for
// RAW/WAW hazard stalls.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   issue_en/issue_rd               decode issues an instruction writing issue_rd
//   issue_rs1_en/rs1, rs2_en/rs2    source operand reads of the issuing instruction
//   alu_valid/rd/data               single-cycle ALU result, always accepted
//   mdu_valid/rd/data, mdu_ready    MDU result handshake into the buffer
//   wr_rd_en/rd_address/rd_data     registered register-file write port
//   reg_rd_stall                    combinational hazard stall
//   busy                            any pending destination, buffered or outgoing write
module reg_writeback
  import rv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_rs1_en,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic                  issue_rs2_en,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mdu_valid,
  input  logic [REG_ADDR_W-1:0] mdu_rd,
  input  logic [XLEN-1:0]       mdu_data,
  output logic                  mdu_ready,
  output logic                  wr_rd_en,
  output logic [REG_ADDR_W-1:0] rd_address,
  output logic [XLEN-1:0]       rd_data,
  output logic                  reg_rd_stall,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic                  wr_en_q;
  logic [REG_ADDR_W-1:0] rd_addr_q;
  logic [XLEN-1:0]       rd_data_q;

  wb_result_t            mdu_res;
  wb_result_t            fifo_head;
  wb_result_t            sel;
  logic                  sel_vld;
  logic                  wr_load;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  assign mdu_res   = '{rd: mdu_rd, data: mdu_data};
  // Readiness comes from registered occupancy only, so a same-cycle pop
  // never opens a slot for a push.
  assign mdu_ready = !fifo_full;
  assign fifo_push = mdu_valid && mdu_ready;
  assign fifo_pop  = !alu_valid && !fifo_empty;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (mdu_res),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ALU always wins the write port; the MDU head drains in ALU-idle cycles.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    if (alu_valid) begin
      sel_vld = 1'b1;
      sel     = '{rd: alu_rd, data: alu_data};
    end else if (!fifo_empty) begin
      sel_vld = 1'b1;
      sel     = fifo_head;
    end
  end

  // x0 results are consumed but never written.
  assign wr_load = sel_vld && (sel.rd != '0);

  // Stall is based on current pending only; the register file forwards the
  // write that lands in the cycle after a clear.
  assign reg_rd_stall = (issue_rs1_en && pending_q[issue_rs1]) ||
                        (issue_rs2_en && pending_q[issue_rs2]) ||
                        (issue_en     && pending_q[issue_rd]);

  // Clear on write load, then set on issue so a fresh issue wins a same-edge tie.
  always_comb begin
    pending_d = pending_q;
    if (wr_load) pending_d[sel.rd] = 1'b0;
    if (issue_en && !reg_rd_stall && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      pending_q <= pending_d;
      wr_en_q   <= wr_load;
      if (wr_load) begin
        rd_addr_q <= sel.rd;
        rd_data_q <= sel.data;
      end
    end
  end

  assign wr_rd_en   = wr_en_q;
  assign rd_address = rd_addr_q;
  assign rd_data    = rd_data_q;
  assign busy       = (|pending_q) || (fifo_count != '0) || wr_en_q;

endmodule : reg_writeback

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;
  import rv_pkg::*;

  logic                  clk;
  logic                  reset;
  logic                  issue_en;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  issue_rs1_en;
  logic [REG_ADDR_W-1:0] issue_rs1;
  logic                  issue_rs2_en;
  logic [REG_ADDR_W-1:0] issue_rs2;
  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  mdu_valid;
  logic [REG_ADDR_W-1:0] mdu_rd;
  logic [XLEN-1:0]       mdu_data;
  logic                  mdu_ready;
  logic                  wr_rd_en;
  logic [REG_ADDR_W-1:0] rd_address;
  logic [XLEN-1:0]       rd_data;
  logic                  reg_rd_stall;
  logic                  busy;

  int unsigned n_pass;
  int unsigned n_total;
  wb_result_t  exp_q[$];

  reg_writeback #(.FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_en     (issue_en),
    .issue_rd     (issue_rd),
    .issue_rs1_en (issue_rs1_en),
    .issue_rs1    (issue_rs1),
    .issue_rs2_en (issue_rs2_en),
    .issue_rs2    (issue_rs2),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .mdu_valid    (mdu_valid),
    .mdu_rd       (mdu_rd),
    .mdu_data     (mdu_data),
    .mdu_ready    (mdu_ready),
    .wr_rd_en     (wr_rd_en),
    .rd_address   (rd_address),
    .rd_data      (rd_data),
    .reg_rd_stall (reg_rd_stall),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && wr_rd_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_rd", 32'(rd_address), 32'hFFFF_FFFF);
      end else begin
        wb_result_t e;
        e = exp_q.pop_front();
        check("wb_rd", 32'(rd_address), 32'(e.rd));
        check("wb_data", rd_data, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_en = 0; issue_rd = '0;
    issue_rs1_en = 0; issue_rs1 = '0;
    issue_rs2_en = 0; issue_rs2 = '0;
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    mdu_valid = 0; mdu_rd = '0; mdu_data = '0;
  endtask

  task automatic expect_wr(input int rd, input logic [31:0] data);
    exp_q.push_back('{rd: REG_ADDR_W'(rd), data: data});
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    idle_inputs();
    reset = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_wr_en", 32'(wr_rd_en), 32'd0);
    check("rst_rd_address", 32'(rd_address), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_mdu_ready", 32'(mdu_ready), 32'd1);
    check("rst_stall", 32'(reg_rd_stall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0;

    // Issue rd5, ALU writes it one cycle later
    issue_en = 1; issue_rd = 5'd5;
    step();
    idle_inputs();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
    expect_wr(5, 32'h1234_5678);
    check("busy_pending5", 32'(busy), 32'd1);
    step();
    idle_inputs();
    check("wr_en_rd5", 32'(wr_rd_en), 32'd1);
    issue_rs1_en = 1; issue_rs1 = 5'd5;
    check("stall_after_clear5", 32'(reg_rd_stall), 32'd0);
    step();
    idle_inputs();

    // RAW stall on rd7; issue during stall is ignored; WAW stall
    issue_en = 1; issue_rd = 5'd7;
    step();
    idle_inputs();
    issue_en = 1; issue_rd = 5'd11; issue_rs1_en = 1; issue_rs1 = 5'd7;
    check("stall_raw7", 32'(reg_rd_stall), 32'd1);
    step();
    idle_inputs();
    issue_en = 1; issue_rd = 5'd7;
    check("stall_waw7", 32'(reg_rd_stall), 32'd1);
    step();
    idle_inputs();
    issue_rs1_en = 1; issue_rs1 = 5'd7;
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'hA5A5_0007;
    expect_wr(7, 32'hA5A5_0007);
    check("stall_held_on_clear_edge", 32'(reg_rd_stall), 32'd1);
    step();
    alu_valid = 0;
    check("stall_drop7", 32'(reg_rd_stall), 32'd0);
    check("wr_en_rd7", 32'(wr_rd_en), 32'd1);
    idle_inputs();
    issue_rs2_en = 1; issue_rs2 = 5'd11;
    check("stalled_issue_ignored", 32'(reg_rd_stall), 32'd0);
    step();
    idle_inputs();

    // ALU and MDU same cycle: ALU first, MDU next
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
    mdu_valid = 1; mdu_rd = 5'd4; mdu_data = 32'h0000_0044;
    expect_wr(3, 32'h0000_0033);
    expect_wr(4, 32'h0000_0044);
    step();
    idle_inputs();
    step();
    step();
    step();

    // ALU held 4 cycles, MDU backs up behind it
    begin
      int ai = 0;
      int mi = 0;
      int cyc = 0;
      logic acc;
      for (int k = 0; k < 4; k++) expect_wr(20 + k, 32'h2000_0000 + 32'(20 + k));
      for (int k = 0; k < 3; k++) expect_wr(8 + k, 32'h8000_0000 + 32'(8 + k));
      while ((ai < 4 || mi < 3) && cyc < 20) begin
        alu_valid = (ai < 4);
        alu_rd    = REG_ADDR_W'(20 + ai);
        alu_data  = 32'h2000_0000 + 32'(20 + ai);
        mdu_valid = (mi < 3);
        mdu_rd    = REG_ADDR_W'(8 + mi);
        mdu_data  = 32'h8000_0000 + 32'(8 + mi);
        if (cyc == 2) begin
          check("mdu_ready_full", 32'(mdu_ready), 32'd0);
          check("mdu_accepts_before_full", 32'(mi), 32'd2);
        end
        acc = mdu_valid && mdu_ready;
        step();
        if (acc) mi++;
        if (ai < 4) ai++;
        cyc++;
      end
      check("mdu_all_accepted", 32'(mi), 32'd3);
      idle_inputs();
      for (int k = 0; k < 5; k++) step();
    end

    // x0 result consumed without a write; port holds previous values
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    check("x0_no_write", 32'(wr_rd_en), 32'd0);
    check("hold_rd_address", 32'(rd_address), 32'd10);
    check("hold_rd_data", rd_data, 32'h8000_000A);
    issue_en = 1; issue_rd = 5'd0;
    check("x0_issue_no_stall", 32'(reg_rd_stall), 32'd0);
    step();
    issue_rs1_en = 1; issue_rs1 = 5'd0;
    check("x0_reissue_no_stall", 32'(reg_rd_stall), 32'd0);
    step();
    idle_inputs();
    step();
    check("idle_not_busy", 32'(busy), 32'd0);

    // Mid-run reset with two buffered MDU results and pending[12]
    issue_en = 1; issue_rd = 5'd12;
    step();
    idle_inputs();
    alu_valid = 1; alu_rd = 5'd13; alu_data = 32'h0000_0013;
    mdu_valid = 1; mdu_rd = 5'd14; mdu_data = 32'h0000_0014;
    expect_wr(13, 32'h0000_0013);
    step();
    alu_rd = 5'd16; alu_data = 32'h0000_0016;
    mdu_rd = 5'd15; mdu_data = 32'h0000_0015;
    expect_wr(16, 32'h0000_0016);
    step();
    alu_valid = 0; mdu_valid = 0;
    check("fifo_full_before_reset", 32'(mdu_ready), 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    issue_rs1_en = 1; issue_rs1 = 5'd12;
    alu_valid = 1; alu_rd = 5'd17; alu_data = 32'h0000_0017;
    #1;
    check("async_rst_wr_en", 32'(wr_rd_en), 32'd0);
    check("async_rst_rd_address", 32'(rd_address), 32'd0);
    check("async_rst_rd_data", rd_data, 32'd0);
    check("async_rst_mdu_ready", 32'(mdu_ready), 32'd1);
    check("async_rst_stall", 32'(reg_rd_stall), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    step();
    step();
    idle_inputs();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_rd_address", 32'(rd_address), 32'd0);

    check("all_writes_seen", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_reg_writeback
